// File: rtl/shader_pkg.sv
// Shared definitions for the shader program store: instruction encodings,
// the built-in reset program and the loader state type.
package shader_pkg;

    localparam int DEF_INSTR_W   = 8;
    localparam int DEF_NUM_INSTR = 10;

    // Encoding: [7:6] opcode class, [5:4] operand A, [3:2] operand B, [1:0] modifier
    localparam logic [DEF_INSTR_W-1:0] OP_NOP       = 8'b01_00_00_00;
    localparam logic [DEF_INSTR_W-1:0] OP_GETX_R0   = 8'b00_01_00_00;
    localparam logic [DEF_INSTR_W-1:0] OP_GETY_R1   = 8'b00_10_01_00;
    localparam logic [DEF_INSTR_W-1:0] OP_XOR_R0_R1 = 8'b10_00_00_01;
    localparam logic [DEF_INSTR_W-1:0] OP_SETRGB_R0 = 8'b11_00_00_00;

    // Slot 0 sits in the least significant byte
    localparam logic [DEF_NUM_INSTR*DEF_INSTR_W-1:0] DEF_PROG = {
        {6{OP_NOP}}, OP_SETRGB_R0, OP_XOR_R0_R1, OP_GETY_R1, OP_GETX_R0
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } load_state_e;

endpackage

// File: rtl/shader_load_ctrl.sv
// Program loader control: accepts exactly NUM_INSTR handshaked words per load
// and flags the last one so the store can reset its program counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | program executes; load_start_i opens a load
// ST_LOAD | ready/busy high; each accepted word shifts into the store
module shader_load_ctrl
    import shader_pkg::*;
#(
    parameter int  NUM_INSTR = DEF_NUM_INSTR,
    localparam int CNT_W     = $clog2(NUM_INSTR)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_start_i,
    input  logic instr_valid_i,
    output logic instr_ready_o,
    output logic load_busy_o,
    output logic load_done_o,
    output logic accept_o,
    output logic last_accept_o
);

    load_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;

    assign accept_o      = instr_valid_i && instr_ready_o;
    assign last_accept_o = accept_o && (cnt_q == CNT_W'(NUM_INSTR - 1));

    // Loader FSM with registered handshake and status outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            instr_ready_o <= 1'b0;
            load_busy_o   <= 1'b0;
            load_done_o   <= 1'b0;
        end else begin
            load_done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start_i) begin
                        state_q       <= ST_LOAD;
                        cnt_q         <= '0;
                        instr_ready_o <= 1'b1;
                        load_busy_o   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (last_accept_o) begin
                        state_q       <= ST_IDLE;
                        cnt_q         <= '0;
                        instr_ready_o <= 1'b0;
                        load_busy_o   <= 1'b0;
                        load_done_o   <= 1'b1;
                    end else if (accept_o) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/shader_program_memory.sv
// Circular instruction store feeding the shader core one instruction per step.
// Slot 0 is the current instruction; loads shift new words in from the top.
module shader_program_memory
    import shader_pkg::*;
#(
    parameter int  INSTR_W   = DEF_INSTR_W,
    parameter int  NUM_INSTR = DEF_NUM_INSTR,
    parameter logic [NUM_INSTR*INSTR_W-1:0] DEFAULT_PROG = DEF_PROG,
    localparam int PC_W      = $clog2(NUM_INSTR)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               shift_i,
    input  logic               load_start_i,
    input  logic               instr_valid_i,
    output logic               instr_ready_o,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               load_busy_o,
    output logic               load_done_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               wrap_o
);

    logic [INSTR_W-1:0] slot_q [NUM_INSTR];
    logic               accept;
    logic               last_accept;
    logic               shift_en;
    logic               pc_at_end;

    shader_load_ctrl #(
        .NUM_INSTR (NUM_INSTR)
    ) u_load_ctrl (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .load_start_i  (load_start_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .load_busy_o   (load_busy_o),
        .load_done_o   (load_done_o),
        .accept_o      (accept),
        .last_accept_o (last_accept)
    );

    // A load request in the same cycle wins over an execution step
    assign shift_en  = shift_i && !load_busy_o && !load_start_i;
    assign pc_at_end = (pc_o == PC_W'(NUM_INSTR - 1));
    assign instr_o   = slot_q[0];

    // Slot array: reset program, rotation on execution, shift-in on load
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_INSTR; k++) begin
                slot_q[k] <= DEFAULT_PROG[k*INSTR_W +: INSTR_W];
            end
        end else if (accept) begin
            for (int k = 0; k < NUM_INSTR - 1; k++) begin
                slot_q[k] <= slot_q[k+1];
            end
            slot_q[NUM_INSTR-1] <= instr_i;
        end else if (shift_en) begin
            for (int k = 0; k < NUM_INSTR - 1; k++) begin
                slot_q[k] <= slot_q[k+1];
            end
            slot_q[NUM_INSTR-1] <= slot_q[0];
        end
    end

    // Program counter tracks slot 0; a completed load realigns it to 0 silently
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_o   <= '0;
            wrap_o <= 1'b0;
        end else begin
            wrap_o <= shift_en && pc_at_end;
            if (last_accept) begin
                pc_o <= '0;
            end else if (shift_en) begin
                pc_o <= pc_at_end ? '0 : pc_o + PC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shader_program_memory.sv
// Directed bench for the shader program store, with a 10-deep and a 5-deep instance.
module tb_shader_program_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       shift, load_start, valid;
    logic [7:0] din;
    logic       ready, busy, done, wrap;
    logic [7:0] dout;
    logic [3:0] pc;

    logic       shift5, load_start5, valid5;
    logic [7:0] din5;
    logic       ready5, busy5, done5, wrap5;
    logic [7:0] dout5;
    logic [2:0] pc5;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];
    logic [7:0] def_prog [10];
    logic [7:0] e;
    int         acc, n, cyc, busy_cyc, wraps;

    shader_program_memory #(.INSTR_W(8), .NUM_INSTR(10)) u_dut10 (
        .clk_i(clk), .rst_ni(rst_n), .shift_i(shift), .load_start_i(load_start),
        .instr_valid_i(valid), .instr_ready_o(ready), .instr_i(din),
        .load_busy_o(busy), .load_done_o(done), .instr_o(dout), .pc_o(pc), .wrap_o(wrap)
    );

    shader_program_memory #(.INSTR_W(8), .NUM_INSTR(5),
                            .DEFAULT_PROG(shader_pkg::DEF_PROG[39:0])) u_dut5 (
        .clk_i(clk), .rst_ni(rst_n), .shift_i(shift5), .load_start_i(load_start5),
        .instr_valid_i(valid5), .instr_ready_o(ready5), .instr_i(din5),
        .load_busy_o(busy5), .load_done_o(done5), .instr_o(dout5), .pc_o(pc5), .wrap_o(wrap5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop the queue against slot 0, rotating the 10-deep program once around
    task automatic readout10(input string tag);
        for (int k = 0; k < 10; k++) begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk(tag, dout, e);
            end
            shift = 1'b1;
            step();
        end
        shift = 1'b0;
        chk({tag, "_drain"}, sb_q.size(), 0);
    endtask

    initial begin
        def_prog = '{8'h10, 8'h24, 8'h81, 8'hC0, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        rst_n = 1'b0; shift = 0; load_start = 0; valid = 0; din = '0;
        shift5 = 0; load_start5 = 0; valid5 = 0; din5 = '0;
        step(); step();
        rst_n = 1'b1;

        chk("rst_instr", dout, 8'b00_0100_00);
        chk("rst_pc", pc, 0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_instr5", dout5, 8'h10);

        // Ten execution steps walk through the default program once
        wraps = 0;
        for (int i = 0; i < 10; i++) begin
            sb_q.push_back(def_prog[(i + 1) % 10]);
            shift = 1'b1;
            step();
            e = sb_q.pop_front();
            chk("shift_instr", dout, e);
            chk("shift_pc", pc, (i + 1) % 10);
            if (wrap) wraps++;
        end
        shift = 1'b0;
        chk("shift_wrap_last", wrap, 1);
        chk("shift_wrap_once", wraps, 1);
        step();
        chk("shift_wrap_clear", wrap, 0);

        // Move pc off zero, then a full load with valid held high
        shift = 1'b1; step(); step(); step(); shift = 1'b0;
        chk("pre_load_pc", pc, 3);
        load_start = 1'b1; step(); load_start = 1'b0;
        chk("load_ready", ready, 1);
        chk("load_busy", busy, 1);
        valid = 1'b1; acc = 0;
        for (int k = 0; k < 10; k++) begin
            din = 8'h11 + 8'(k);
            sb_q.push_back(din);
            if (ready) acc++;
            step();
            chk("load_done_pulse", done, (k == 9));
        end
        valid = 1'b0;
        chk("load_accepts", acc, 10);
        chk("load_ready_off", ready, 0);
        chk("load_busy_off", busy, 0);
        chk("load_pc", pc, 0);
        chk("load_wrap", wrap, 0);
        chk("load_instr", dout, 8'h11);
        step();
        chk("load_done_clear", done, 0);
        readout10("load_readout");

        // Load with valid low/high alternating
        load_start = 1'b1; step(); load_start = 1'b0;
        cyc = 0; n = 0; busy_cyc = 0;
        while (n < 10 && cyc < 40) begin
            valid = cyc[0];
            din = 8'h31 + 8'(n);
            if (busy) busy_cyc++;
            if (valid && ready) begin
                sb_q.push_back(din);
                n++;
            end
            step();
            cyc++;
        end
        valid = 1'b0;
        chk("gap_words", n, 10);
        chk("gap_load_cycles", busy_cyc, 20);
        chk("gap_done", done, 1);
        chk("gap_busy_off", busy, 0);
        chk("gap_instr", dout, 8'h31);
        readout10("gap_readout");

        // Shift held throughout, including the load_start cycle
        shift = 1'b1; load_start = 1'b1; step(); load_start = 1'b0;
        chk("prio_busy", busy, 1);
        chk("prio_pc", pc, 0);
        chk("prio_instr", dout, 8'h31);
        valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            din = 8'h41 + 8'(k);
            sb_q.push_back(din);
            step();
        end
        shift = 1'b0; valid = 1'b0;
        chk("shiftload_done", done, 1);
        chk("shiftload_instr", dout, 8'h41);
        chk("shiftload_pc", pc, 0);
        readout10("shiftload_readout");

        // Reset after four accepted words restores the default program
        load_start = 1'b1; step(); load_start = 1'b0;
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din = 8'h61 + 8'(k);
            step();
        end
        valid = 1'b0;
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 0);
        chk("abort_instr", dout, 8'b00_0100_00);
        chk("abort_pc", pc, 0);
        for (int k = 0; k < 10; k++) sb_q.push_back(def_prog[k]);
        readout10("abort_readout");

        // Five-deep instance: non power-of-two wrap and load
        wraps = 0;
        for (int i = 0; i < 7; i++) begin
            shift5 = 1'b1;
            step();
            chk("n5_instr", dout5, def_prog[(i + 1) % 5]);
            if (wrap5) wraps++;
        end
        shift5 = 1'b0;
        chk("n5_pc", pc5, 2);
        chk("n5_wraps", wraps, 1);
        load_start5 = 1'b1; step(); load_start5 = 1'b0;
        valid5 = 1'b1; acc = 0;
        for (int k = 0; k < 5; k++) begin
            din5 = 8'h51 + 8'(k);
            sb_q.push_back(din5);
            if (ready5) acc++;
            step();
        end
        valid5 = 1'b0;
        chk("n5_accepts", acc, 5);
        chk("n5_done", done5, 1);
        chk("n5_pc_after", pc5, 0);
        for (int k = 0; k < 5; k++) begin
            e = sb_q.pop_front();
            chk("n5_readout", dout5, e);
            shift5 = 1'b1;
            step();
        end
        shift5 = 1'b0;
        chk("n5_back_to_start", dout5, 8'h51);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
